// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control path: FSM states, opcodes,
// and the select codes consumed by the datapath and the ALU control decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_main_control.sv
// Moore main control FSM for the multi-cycle MIPS datapath. Outputs decode the
// registered state only, except FETCH's PC/IR writes which wait on mem_ready.
module mips_main_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_RTWB;
            // MEMWB, RTWB, BRANCH, JUMP and any stray encoding all return to FETCH
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_REG;
        pcsource    = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = SRCB_IMMSH;
                illegal_op = !op_supported(opcode);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multi-cycle main control unit for the MIPS datapath: the producer of the 2-bit `aluop` code that the ALU control decoder consumes. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and muxes, and it stalls on a memory-ready handshake. It sits between the instruction register's opcode field and the datapath/ALU-control inputs.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite` out 1 each: PC, memory and IR controls.
- `memtoreg`, `regdst`, `regwrite`, `alusrca` out 1 each: register file and ALU-A controls.
- `alusrcb` out 2: ALU-B select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `pcsource` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state_dbg` out 4: current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
- Outputs are Moore: a combinational decode of the registered state only. Exceptions: `pcwrite` and `irwrite` in FETCH are additionally ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- FETCH (0):
  - Outputs: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsource`=00.
  - `irwrite`=`pcwrite`=`mem_ready`.
  - Stay while `mem_ready`=0; go to DECODE when 1.
- DECODE (1):
  - Outputs: `alusrca`=0, `alusrcb`=11, `aluop`=00.
  - Next state by opcode: lw/sw → MEMADR, R-type → EXEC, beq → BRANCH, j → JUMP.
  - Any other opcode: `illegal_op`=1 this cycle and go to FETCH.
- MEMADR (2):
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Next: lw → MEMRD, sw → MEMWR.
- MEMRD (3):
  - Outputs: `memread`=1, `iord`=1.
  - Stay until `mem_ready`=1, then go to MEMWB.
- MEMWB (4): `regwrite`=1, `memtoreg`=1, `regdst`=0. Next FETCH.
- MEMWR (5):
  - Outputs: `memwrite`=1, `iord`=1.
  - Stay until `mem_ready`=1, then go to FETCH.
- EXEC (6): `alusrca`=1, `alusrcb`=00, `aluop`=10. Next RTWB.
- RTWB (7): `regwrite`=1, `regdst`=1, `memtoreg`=0. Next FETCH.
- BRANCH (8):
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcwritecond`=1, `pcsource`=01.
  - Next FETCH.
- JUMP (9): `pcwrite`=1, `pcsource`=10. Next FETCH.
- Encodings 10–15 are unreachable. If ever entered, go to FETCH next cycle with all outputs 0.
- `illegal_op` is decoded from state DECODE and `opcode`, so it is asserted only in DECODE.

## Timing
- Reset: `reset`=1 at a rising edge forces FETCH on that edge. This overrides any state, including a stalled MEMRD or MEMWR; the pending access is abandoned.
- Outputs after reset are the FETCH values above. `pcwrite`/`irwrite` are 0 unless `mem_ready`=1; every other output not listed for FETCH is 0.
- Cycle counts with `mem_ready` held 1:
  - lw 5 cycles.
  - sw 4 cycles.
  - R-type 4 cycles.
  - beq 3 cycles.
  - j 3 cycles.
  - illegal opcode 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- During a stall, outputs hold steady: `memread` and `iord` do not glitch, and no write strobe asserts.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from the FETCH cycle in which `irwrite`=1 until the instruction returns to FETCH.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the 4-bit state enum;
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`);
  - the `aluop` constants (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10), shared with the ALU control decoder;
  - the `alusrcb` and `pcsource` select constants.
- Single module with no sub-module: a state register, a next-state block and an output-decode block.

## Test plan
- Reset mid-MEMRD: `reset`=1 for 1 cycle → next cycle `state_dbg`=0, `memread`=1, `memwrite`=0, `regwrite`=0.
- lw 100011 with `mem_ready`=1 throughout:
  - state sequence 0,1,2,3,4,0;
  - `aluop`=00 in 0/1/2;
  - `regwrite`=1 and `memtoreg`=1 only in cycle 5.
- sw 101011 with `mem_ready` low for 3 cycles in MEMWR: MEMWR lasts 4 cycles with `memwrite`=1 throughout, then FETCH; total 7 cycles.
- R-type 000000: `aluop`=10 and `alusrcb`=00 in EXEC; `regwrite`=1 and `regdst`=1 in RTWB; 4 cycles.
- beq 000100 then j 000010:
  - BRANCH has `aluop`=01, `pcwritecond`=1, `pcsource`=01;
  - JUMP has `pcwrite`=1, `pcsource`=10;
  - 3 cycles each.
- Opcode 001000 (unsupported): `illegal_op`=1 for exactly one cycle in DECODE, return to FETCH, no write strobe at any point.
